mux3_rr_arbiter: RTL and testbench
==================================

Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 3:1 selection datapath (encodings 2'b00/01/10, anything else yields zero) among three requesters.
- Owns the 2-bit select bus and drives it from a registered grant.
- An optional hold limit preempts a requester that holds the datapath too long while others wait.
- Sits between requesting units (e.g. fetch, load/store, debug) and the shared mux.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before preemption when another requester is pending; 0 disables preemption.
- CNT_W, $clog2(MAX_HOLD+1) (minimum 1), width of the hold counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  3  request per requester; level, held high for as long as access is wanted.
- gnt  output  3  one-hot registered grant; all zero when idle.
- sel  output  2  mux select: 2'b00/01/10 for owners 0/1/2; 2'b11 when idle, so the mux outputs zero.
- busy  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse on the cycle a grant is forcibly removed by the hold limit.

Behaviour:
- Reset (async assert, sync-safe deassert): gnt=3'b000, sel=2'b11, busy=0, preempt=0, hold_cnt=0, state=IDLE, last_owner=2, so requester 0 has first priority.
- States:
  - IDLE: no owner.
  - GRANT: owner k. sel and gnt always reflect the owner; sel, gnt and busy are derived from registered state only.
- Round-robin pick: search order last_owner+1, +2, +3 (mod 3) over the candidate set. The first set bit wins. last_owner updates to the winner on every new grant.
- IDLE:
  - Any req bit high at an edge → GRANT to the RR winner over req; gnt/sel valid the next cycle (1-cycle latency).
  - hold_cnt is set to 0 on entry.
- GRANT, evaluated each edge:
  - release: req[k]==0 → pick over req; if none, go IDLE (sel=2'b11).
  - preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and req & ~(1<<k) != 0 → pick over req with bit k masked; preempt=1 for exactly the next cycle; k keeps its request and competes normally afterwards.
  - otherwise: hold_cnt increments, saturating at MAX_HOLD-1.
  - Any handover loads hold_cnt=0. Handover is back-to-back: no idle bubble between owners.
- Simultaneous events:
  - Owner drops req on the same edge the limit is reached → treated as release; preempt stays 0.
  - Several new requests in one cycle → RR order resolves.
- No other pending requester at the limit → owner keeps the grant indefinitely and the counter stays saturated.
- req bits of non-owners never affect sel during GRANT except through a handover.
- Reset mid-grant → gnt drops immediately (asynchronous); sel=2'b11.
- Invariants: gnt is one-hot or zero; busy == |gnt; sel==2'b11 iff gnt==0.

Decomposition:
- Shared package: SEL_IDLE=2'b11, SEL_REQ0/1/2 encodings, and the state enum {IDLE, GRANT}.
- One natural sub-module: rr_pick3. It is combinational: candidate mask plus last_owner in, one-hot winner plus valid out. It is reused for both release and preempt picks.

Test Plan:
- Reset with req=3'b111, then release rst_n → after the first edge gnt=3'b001, sel=2'b00, busy=1.
- req0 held 3 cycles then dropped while req=3'b110 → gnt 001 → 010 on the next edge with no idle cycle; req1 drops → gnt=100, sel=2'b10.
- MAX_HOLD=4, req1 held continuously, req2 raised at grant cycle 1 → gnt=010 for 4 cycles, then gnt=100 with preempt=1 for one cycle; req1 is regranted after req2 drops.
- Owner drops req on exactly the limit cycle while another is pending → handover occurs and preempt stays 0.
- All req deasserted during GRANT → the next cycle has gnt=000, sel=2'b11, busy=0; a single req2 pulse then yields gnt=100 one cycle later.
- Assert rst_n=0 mid-grant between edges → gnt=000 and sel=2'b11 immediately; on release, priority restarts at requester 0.

Source files
------------

// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared encodings for the 3:1 select bus and the arbiter state type.
package mux3_rr_arbiter_pkg;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // A zero vector maps to SEL_IDLE so the shared mux outputs zero.
    function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
        logic [1:0] s;
        s = SEL_IDLE;
        if (oh[0]) s = SEL_REQ0;
        else if (oh[1]) s = SEL_REQ1;
        else if (oh[2]) s = SEL_REQ2;
        return s;
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Combinational round-robin pick: searches last+1, last+2, last+3 (mod 3).
module rr_pick3
    import mux3_rr_arbiter_pkg::*;
(
    input  logic [2:0] cand_i,
    input  logic [1:0] last_i,
    output logic [2:0] win_o,
    output logic       valid_o
);

    int idx;

    always_comb begin
        win_o = 3'b000;
        idx   = 0;
        for (int i = 1; i <= 3; i++) begin
            idx = (int'(last_i) + i) % 3;
            if ((win_o == 3'b000) && cand_i[idx]) begin
                win_o[idx] = 1'b1;
            end
        end
    end

    assign valid_o = |cand_i;

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner of the 3:1 datapath select bus with an optional hold limit.
module mux3_rr_arbiter
    import mux3_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_e           state_q;
    logic [2:0]       gnt_q;
    logic [1:0]       sel_q;
    logic             busy_q;
    logic             preempt_q;
    logic [1:0]       last_owner_q;
    logic [CNT_W-1:0] hold_cnt_q;

    logic       owner_req;
    logic       others_pending;
    logic       limit_hit;
    logic [2:0] cand;
    logic [2:0] win;
    logic       win_valid;

    assign owner_req      = |(req & gnt_q);
    assign others_pending = |(req & ~gnt_q);
    assign limit_hit      = (MAX_HOLD != 0) && (state_q == GRANT) && (hold_cnt_q == HOLD_MAX);

    // Masking the owner is harmless on release (its bit is already low),
    // so one picker serves both the release and the preempt handover.
    assign cand = limit_hit ? (req & ~gnt_q) : req;

    rr_pick3 u_pick (
        .cand_i  (cand),
        .last_i  (last_owner_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 3'b000;
            sel_q        <= SEL_IDLE;
            busy_q       <= 1'b0;
            preempt_q    <= 1'b0;
            last_owner_q <= SEL_REQ2;
            hold_cnt_q   <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q      <= GRANT;
                        gnt_q        <= win;
                        sel_q        <= onehot_to_sel(win);
                        busy_q       <= 1'b1;
                        last_owner_q <= onehot_to_sel(win);
                        hold_cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || (limit_hit && others_pending)) begin
                        if (win_valid) begin
                            gnt_q        <= win;
                            sel_q        <= onehot_to_sel(win);
                            last_owner_q <= onehot_to_sel(win);
                            hold_cnt_q   <= '0;
                            preempt_q    <= owner_req;
                        end else begin
                            state_q    <= IDLE;
                            gnt_q      <= 3'b000;
                            sel_q      <= SEL_IDLE;
                            busy_q     <= 1'b0;
                            hold_cnt_q <= '0;
                        end
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 3'b000;
                    sel_q   <= SEL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: directed scenarios then random traffic against a grant-history model.
module tb_mux3_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  int n_tests = 0;
  int n_fail  = 0;

  // model: owner index (-1 idle), last winner, cycles the owner has held the grant
  int m_owner;
  int m_last;
  int m_held;
  bit m_pre;

  mux3_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(input logic [2:0] c, input int last);
    for (int i = 1; i <= 3; i++) begin
      if (c[(last + i) % 3]) return (last + i) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_held  = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] r);
    int w;
    logic [2:0] others;
    w = -1;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      w = pick(r, m_last);
    end else if (!r[m_owner]) begin
      w = pick(r, m_last);
      if (w < 0) m_owner = -1;
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != 3'b000) begin
        w = pick(others, m_last);
        m_pre = 1'b1;
      end else begin
        m_held++;
      end
    end
    if (w >= 0) begin
      m_owner = w;
      m_last  = w;
      m_held  = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [2:0] e_gnt;
    logic [1:0] e_sel;
    e_gnt = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    e_sel = (m_owner < 0) ? 2'b11 : 2'(m_owner);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".sel"}, {1'b0, sel}, {1'b0, e_sel});
    chk({tag, ".busy"}, {2'b00, busy}, {2'b00, (m_owner >= 0)});
    chk({tag, ".preempt"}, {2'b00, preempt}, {2'b00, m_pre});
  endtask

  task automatic step(input string tag, input logic [2:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [2:0] r;
    rst_n = 1'b0;
    req   = 3'b111;
    model_reset();
    #12;
    check_model("reset");
    rst_n = 1'b1;

    step("first_grant", 3'b111);
    chk("first_grant.lit", gnt, 3'b001);
    step("hold0_c2", 3'b111);
    step("hold0_c3", 3'b111);
    step("handover01", 3'b110);
    chk("handover01.lit", gnt, 3'b010);
    step("handover12", 3'b100);
    chk("handover12.lit", {1'b0, sel}, 3'b010);

    step("to_idle", 3'b000);
    step("pre_g1", 3'b010);
    step("pre_g2", 3'b110);
    step("pre_g3", 3'b110);
    step("pre_g4", 3'b110);
    step("pre_fire", 3'b110);
    chk("pre_fire.lit", {preempt, gnt}, 4'b1100);
    step("pre_after", 3'b110);
    step("regrant1", 3'b010);
    chk("regrant1.lit", gnt, 3'b010);

    step("to_idle2", 3'b000);
    step("lim_g1", 3'b001);
    step("lim_g2", 3'b011);
    step("lim_g3", 3'b011);
    step("lim_g4", 3'b011);
    step("lim_release", 3'b010);
    chk("lim_release.lit", {preempt, gnt}, 4'b0010);

    step("sat_g1", 3'b010);
    for (int i = 0; i < 6; i++) step("sat_hold", 3'b010);
    step("sat_fire", 3'b011);
    chk("sat_fire.lit", {preempt, gnt}, 4'b1001);

    step("all_drop", 3'b000);
    chk("all_drop.lit", {busy, sel, gnt}, 6'b011000);
    step("pulse2", 3'b100);
    chk("pulse2.lit", gnt, 3'b100);
    step("pulse2_end", 3'b100);

    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    #2;
    req = 3'b111;
    rst_n = 1'b1;
    step("rst_restart", 3'b111);
    chk("rst_restart.lit", gnt, 3'b001);

    r = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      step("rand", r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
